// File: rtl/clock_divider.sv
// Integer clock divider: a registered, glitch-free clk_out with a period of DIV
// clk cycles. It is low for DIV-HIGH cycles, then high for HIGH cycles.
module clock_divider #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  output logic clk_out
);

  // Clamp the width so a bad DIV still elaborates far enough to report the error.
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int HIGH  = DIV / 2;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_RISE = CNT_W'(DIV - HIGH);

  if (DIV < 2) begin : g_bad_div
    $error("clock_divider: DIV must be >= 2");
  end

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             clk_out_q;

  // Explicit wrap at DIV-1, so a power-of-two DIV does not depend on natural overflow.
  always_comb begin
    cnt_next = (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt       <= '0;
      clk_out_q <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      clk_out_q <= (cnt_next >= CNT_RISE);
    end
  end

  assign clk_out = clk_out_q;

endmodule

// File: tb/tb_clock_divider.sv
// Directed bench for clock_divider. Four instances (DIV = 10, 3, 2, 16) share
// one clock and one reset and are checked edge by edge.
module tb_clock_divider;

  logic       clk;
  logic       reset;
  logic [3:0] co;
  int         divs [4] = '{10, 3, 2, 16};
  int         errors = 0;
  int         checks = 0;

  clock_divider #(.DIV(10)) u_div10 (.clk(clk), .reset(reset), .clk_out(co[0]));
  clock_divider #(.DIV(3))  u_div3  (.clk(clk), .reset(reset), .clk_out(co[1]));
  clock_divider #(.DIV(2))  u_div2  (.clk(clk), .reset(reset), .clk_out(co[2]));
  clock_divider #(.DIV(16)) u_div16 (.clk(clk), .reset(reset), .clk_out(co[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Expected level after the k-th run edge following release.
  function automatic logic exp_out(input int div, input int k);
    return ((k % div) >= (div - div / 2));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run n edges after a release, checking every instance against the waveform rule.
  task automatic run_check(input string tag, input int n, output logic [63:0] trace);
    trace = '0;
    for (int k = 1; k <= n; k++) begin
      step();
      for (int d = 0; d < 4; d++)
        chk($sformatf("%s div%0d edge%0d", tag, divs[d], k), co[d], exp_out(divs[d], k));
      if (k <= 64) trace[k-1] = co[0];
    end
  endtask

  logic [20:1]  tbl10;
  logic [63:0]  tr_a, tr_b, tr_tmp;
  int           high_cnt, rise_cnt;
  logic         prev;

  initial begin
    // DIV=10 edges 1..20 after release: low 1-4, high 5-9, low 10-14, high 15-19, low 20
    tbl10 = 20'b0111_1100_0001_1111_0000;

    // Reset for two edges; every output held low.
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      for (int d = 0; d < 4; d++)
        chk($sformatf("reset div%0d cyc%0d", divs[d], i), co[d], 1'b0);
    end

    // Release: 100 edges, hand table for the first 20 of DIV=10, plus period/duty counts.
    @(negedge clk);
    reset = 1'b1;
    high_cnt = 0;
    rise_cnt = 0;
    prev     = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (k <= 20) chk($sformatf("tbl10 edge%0d", k), co[0], tbl10[k]);
      for (int d = 1; d < 4; d++)
        chk($sformatf("run div%0d edge%0d", divs[d], k), co[d], exp_out(divs[d], k));
      if (co[0]) high_cnt++;
      if (co[0] && !prev) rise_cnt++;
      prev = co[0];
    end
    chk("div10 high cycles==50", (high_cnt == 50), 1'b1);
    chk("div10 rises==10", (rise_cnt == 10), 1'b1);

    // Advance DIV=10 to edge 107 (high phase), then reset mid-period.
    for (int k = 101; k <= 107; k++) step();
    chk("div10 high before midreset", co[0], 1'b1);
    @(negedge clk);
    reset = 1'b0;
    step();
    for (int d = 0; d < 4; d++)
      chk($sformatf("midreset div%0d", divs[d]), co[d], 1'b0);
    @(negedge clk);
    reset = 1'b1;
    run_check("after midreset", 20, tr_tmp);
    for (int k = 1; k <= 20; k++)
      chk($sformatf("midreset tbl10 edge%0d", k), tr_tmp[k-1], tbl10[k]);

    // Long reset (1000 ns) twice; traces after each release must be identical.
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) step();
    chk("long reset div10 low", co[0], 1'b0);
    @(negedge clk);
    reset = 1'b1;
    run_check("release1", 48, tr_a);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) step();
    chk("long reset2 div16 low", co[3], 1'b0);
    @(negedge clk);
    reset = 1'b1;
    run_check("release2", 48, tr_b);
    chk("release traces equal", (tr_a == tr_b), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
